sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data bits per entry.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
REQ-005 Port wr_en  input  1  write request.
REQ-006 Port wr_data  input  WIDTH  write data.
REQ-007 Port full  output  1  high when count == DEPTH.
REQ-008 Port rd_en  input  1  read request (pop).
REQ-009 Port rd_data  output  WIDTH  head entry (oldest data).
REQ-010 Port empty  output  1  high when count == 0.
REQ-011 Port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 Port wr_err  output  1  one-cycle pulse on a rejected write.
REQ-013 Port rd_err  output  1  one-cycle pulse on a rejected read.

Function
REQ-014 A write is accepted when wr_en=1 and (full=0 or rd_en=1); wr_data is stored at the tail on that edge.
REQ-015 A read is accepted when rd_en=1 and empty=0; the head entry is removed on that edge.
REQ-016 rd_data shall be first-word-fall-through: combinationally equal to the head entry whenever empty=0, and 0 when empty=1.
REQ-017 Write-to-read latency: data written at edge N appears on rd_data after edge N when the FIFO was empty before N.
REQ-018 count shall increment on write-only, decrement on read-only, and hold on simultaneous accepted read and write or on no operation.
REQ-019 full and empty shall be derived from count and valid in the same cycle count changes.
REQ-020 When full, a simultaneous rd_en=1 and wr_en=1 shall accept both; count stays DEPTH.
REQ-021 When empty, a simultaneous rd_en=1 and wr_en=1 shall accept the write only, raise rd_err, and set count to 1.
REQ-022 wr_en=1 while full and rd_en=0 shall leave state unchanged and pulse wr_err high for the following cycle.
REQ-023 rd_en=1 while empty shall leave state unchanged and pulse rd_err high for the following cycle.
REQ-024 Read and write pointers shall be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-025 Entries shall be delivered in strict write order; no entry is duplicated or dropped across wrap-around.

Reset
REQ-026 reset=0 at a clock edge shall clear both pointers and count to 0, and clear wr_err and rd_err to 0.
REQ-027 After reset, outputs shall be empty=1, full=0, and rd_data=0.
REQ-028 Reset shall take priority over wr_en and rd_en in the same cycle; a request in the reset cycle is dropped with no error pulse.
REQ-029 Storage contents need not be cleared by reset and shall never be visible while empty=1.

Structure
REQ-030 A shared package fifo_pkg shall hold the default constants FIFO_WIDTH=32 and FIFO_DEPTH=8, used as parameter defaults.
REQ-031 Storage shall be a sub-module fifo_mem: a DEPTH x WIDTH register array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
REQ-032 Pointer, count and error logic shall live in sync_fifo; no latches and no asynchronous paths other than the rd_data read mux.

Verification
REQ-033 Reset then idle 3 cycles -> empty=1, full=0, count=0, rd_data=0, wr_err=0, rd_err=0.
REQ-034 Write 0xA0..0xA7 on 8 consecutive cycles, then read 8 -> full=1 after the 8th write; reads return 0xA0..0xA7 in order; empty=1 at end.
REQ-035 Full FIFO plus wr_en=1 with data 0xDEAD and rd_en=0 -> wr_err pulses for 1 cycle; count stays 8; 0xDEAD is never read.
REQ-036 Full FIFO plus simultaneous rd_en=1 and wr_en=1 with data 0x55 -> head popped, count stays 8, and 0x55 is read last after 7 further reads.
REQ-037 Empty FIFO plus simultaneous rd_en=1 and wr_en=1 with data 0x11 -> rd_err pulses, count=1, rd_data=0x11 the next cycle.
REQ-038 Write 5, read 5, write 6, then assert reset=0 mid-stream -> pointers wrap correctly before reset; after reset, empty=1, count=0, and the next write/read pair returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO slice.
// Default geometry used by sync_fifo and fifo_mem when no parameters are overridden.
package fifo_pkg;

  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: one synchronous write port and one
// combinational read port so the head entry can fall through without a cycle of delay.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the controller masks them while empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: pointer, occupancy and error-pulse
// control around a fifo_mem register array.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_err,
  output logic                     rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_accept;
  logic             rd_accept;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still takes a write when a read frees the head slot on the same edge.
  always_comb begin
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_en);
    mem_we    = wr_accept && reset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wr_err <= wr_en && full && !rd_en;
      rd_err <= rd_en && empty;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Stale storage must never leak out while the FIFO holds nothing.
  assign rd_data = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with hand-computed expectations
// covering reset, ordering, wrap-around, full/empty corner cases and error pulses.
module tb_sync_fifo;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic [3:0]  count;
  logic        wr_err;
  logic        rd_err;

  int checks;
  int errors;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count),
    .wr_err  (wr_err),
    .rd_err  (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 ns after the edge with the bus idle.
  task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rd, input logic rst_n);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    reset   = rst_n;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic readExpect(input string tag, input logic [31:0] exp);
    checkOutput(tag, rd_data, exp);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    // Reset with requests pending: they must be dropped silently.
    applyStimulus(1'b1, 32'h99, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h98, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    checkOutput("rst_rd_err", 32'(rd_err), 32'd0);

    // Fill with 0xA0..0xA7, then drain in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1);
      checkOutput("fill_count", 32'(count), 32'(i + 1));
      if (i == 0) checkOutput("fwft_first", rd_data, 32'hA0);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 8; i++) readExpect("drain_data", 32'hA0 + 32'(i));
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_rd_data", rd_data, 32'd0);

    // Overflow attempt on a full FIFO.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1);
    checkOutput("ovf_wr_err", 32'(wr_err), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd8);
    checkOutput("ovf_head", rd_data, 32'hB0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("ovf_wr_err_clear", 32'(wr_err), 32'd0);

    // Full FIFO with simultaneous read and write.
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b1);
    checkOutput("fullrw_count", 32'(count), 32'd8);
    checkOutput("fullrw_wr_err", 32'(wr_err), 32'd0);
    checkOutput("fullrw_rd_err", 32'(rd_err), 32'd0);
    for (int i = 1; i < 8; i++) readExpect("fullrw_data", 32'hB0 + 32'(i));
    readExpect("fullrw_last", 32'h55);
    checkOutput("fullrw_empty", 32'(empty), 32'd1);

    // Empty FIFO with simultaneous read and write: write only.
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b1);
    checkOutput("emptyrw_rd_err", 32'(rd_err), 32'd1);
    checkOutput("emptyrw_wr_err", 32'(wr_err), 32'd0);
    checkOutput("emptyrw_count", 32'(count), 32'd1);
    checkOutput("emptyrw_data", rd_data, 32'h11);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("emptyrw_rd_err_clear", 32'(rd_err), 32'd0);
    readExpect("emptyrw_pop", 32'h11);
    checkOutput("emptyrw_empty", 32'(empty), 32'd1);

    // Underflow attempt on an empty FIFO.
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("udf_rd_err", 32'(rd_err), 32'd1);
    checkOutput("udf_count", 32'(count), 32'd0);
    checkOutput("udf_rd_data", rd_data, 32'd0);

    // Pointer wrap: write 5, read 5, write 6, then reset mid-stream.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) readExpect("wrap_c_data", 32'hC0 + 32'(i));
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b1);
    checkOutput("wrap_count", 32'(count), 32'd6);
    checkOutput("wrap_head", rd_data, 32'hD0);
    applyStimulus(1'b1, 32'hEE, 1'b1, 1'b0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_rd_data", rd_data, 32'd0);
    checkOutput("midrst_wr_err", 32'(wr_err), 32'd0);
    checkOutput("midrst_rd_err", 32'(rd_err), 32'd0);
    applyStimulus(1'b1, 32'hE1, 1'b0, 1'b1);
    checkOutput("post_rst_count", 32'(count), 32'd1);
    readExpect("post_rst_data", 32'hE1);
    checkOutput("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
